// File: rtl/issue_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : issue_ctrl_pkg                                                   |
// | Brief   : Shared funct codes, mult/div op encoding and FSM states.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package issue_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam int CNT_W = 6;

  // Bit 1 selects divide, bit 0 selects unsigned (matches funct[0]).
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_hilo_move(input logic [5:0] funct);
    return (funct == FUNCT_MFHI) || (funct == FUNCT_MTHI) ||
           (funct == FUNCT_MFLO) || (funct == FUNCT_MTLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_ctrl_md_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : md_counter                                                       |
// | Brief   : Loadable down-counter with zero flag; saturates at zero.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module md_counter
  import issue_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : issue_ctrl                                                       |
// | Brief   : ID-stage hazard detection and mult/div issue sequencing.         |
// |           ISSUE_CTRL_DIV_EN enables DIV/DIVU issue.                        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [5:0] id_op,
  input  logic [5:0] id_funct,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_read,
  input  logic       id_rt_read,
  input  logic       ex_load,
  input  logic [4:0] ex_wb_addr,
  input  logic       flush,
  output logic       stall_req,
  output logic       bubble,
  output logic       md_start,
  output logic [1:0] md_op,
  output logic       md_busy,
  output logic       md_done
);

  localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES - 1);

  md_state_e r_state;
  md_op_e    r_md_op;
  logic      r_run;

  logic      w_special;
  logic      w_is_mult;
  logic      w_is_div;
  logic      w_is_md;
  logic      w_is_hilo;
  logic      w_load_use;
  logic      w_hilo_hazard;
  logic      w_issue_ok;
  logic      w_stall;
  logic      w_md_start;
  logic      w_busy;
  logic      w_cnt_zero;
  md_op_e    w_op;
  logic [CNT_W-1:0] w_load_val;

  assign w_special = (id_op == OP_SPECIAL);
  assign w_is_mult = w_special &&
                     ((id_funct == FUNCT_MULT) || (id_funct == FUNCT_MULTU));
`ifdef ISSUE_CTRL_DIV_EN
  assign w_is_div  = w_special &&
                     ((id_funct == FUNCT_DIV) || (id_funct == FUNCT_DIVU));
`else
  assign w_is_div  = 1'b0;
`endif
  assign w_is_md   = w_is_mult || w_is_div;
  assign w_is_hilo = (w_special && is_hilo_move(id_funct)) || w_is_md;
  assign w_op      = md_op_e'({w_is_div, id_funct[0]});

  assign w_load_use = ex_load && (ex_wb_addr != 5'd0) &&
                      ((id_rs_read && (id_rs == ex_wb_addr)) ||
                       (id_rt_read && (id_rt == ex_wb_addr)));

  assign w_busy        = (r_state == ST_BUSY);
  assign w_hilo_hazard = w_busy && w_is_hilo;

  // r_run is cleared by reset so every pulse output reads 0 while rst is low.
  assign w_issue_ok = r_run && id_valid && !flush;
  assign w_stall    = w_issue_ok && (w_load_use || w_hilo_hazard);
  assign w_md_start = w_issue_ok && w_is_md && !w_stall;
  assign w_load_val = w_is_div ? c_div_load : c_mult_load;

  assign stall_req = w_stall;
  assign bubble    = w_stall;
  assign md_start  = w_md_start;
  assign md_op     = w_md_start ? w_op : r_md_op;
  assign md_busy   = w_busy;
  assign md_done   = w_busy && w_cnt_zero;

  md_counter #(
    .WIDTH (CNT_W)
  ) u_md_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (w_md_start),
    .load_val (w_load_val),
    .dec      (w_busy),
    .zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_md_op <= MD_MULT;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_md_start) begin
        r_md_op <= w_op;
      end
      case (r_state)
        ST_IDLE: if (w_md_start) r_state <= ST_BUSY;
        ST_BUSY: if (w_cnt_zero) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
